// File: rtl/tx_fifo_arbiter.sv
// Round-robin drain of two sources' c0/c1/c2 Tx FIFOs onto one registered CCI-P Tx port.
// Optional per-source issue counters are enabled with `define TX_ARB_STATS_EN.

package tx_fifo_arbiter_pkg;
  typedef struct packed {
    logic [15:0] hdr;
    logic        valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    logic [15:0] hdr;
    logic [31:0] data;
    logic        valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    logic [7:0]  hdr;
    logic        mmioRdValid;
    logic [31:0] data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;
endpackage

module tx_fifo_arbiter
  import tx_fifo_arbiter_pkg::*;
#(
  parameter int unsigned PRIORITY_SRC = 0,
  parameter int unsigned STAT_WIDTH   = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_s0_c0_notEmpty,
  input  t_if_ccip_c0_Tx            in_s0_c0_first,
  output logic                      out_s0_c0_deq_en,
  input  logic                      in_s1_c0_notEmpty,
  input  t_if_ccip_c0_Tx            in_s1_c0_first,
  output logic                      out_s1_c0_deq_en,
  input  logic                      in_s0_c1_notEmpty,
  input  t_if_ccip_c1_Tx            in_s0_c1_first,
  output logic                      out_s0_c1_deq_en,
  input  logic                      in_s1_c1_notEmpty,
  input  t_if_ccip_c1_Tx            in_s1_c1_first,
  output logic                      out_s1_c1_deq_en,
  input  logic                      in_s0_c2_notEmpty,
  input  t_if_ccip_c2_Tx            in_s0_c2_first,
  output logic                      out_s0_c2_deq_en,
  input  logic                      in_s1_c2_notEmpty,
  input  t_if_ccip_c2_Tx            in_s1_c2_first,
  output logic                      out_s1_c2_deq_en,
  input  logic                      in_c0TxAlmFull,
  input  logic                      in_c1TxAlmFull,
  output t_if_ccip_Tx               out_TxPort,
  output logic [2*STAT_WIDTH-1:0]   out_stat_c0_cnt,
  output logic [2*STAT_WIDTH-1:0]   out_stat_c1_cnt,
  output logic [2*STAT_WIDTH-1:0]   out_stat_c2_cnt
);

  localparam logic PRIO = 1'(PRIORITY_SRC);

  // Bit N of each vector refers to channel cN; lastGnt[N]=1 means source 1 won last.
  logic [2:0] chOpen;
  logic [2:0] req0, req1;
  logic [2:0] gnt0, gnt1;
  logic [2:0] lastGnt;
  t_if_ccip_Tx nxtTx;

  // Same-cycle eligibility and round-robin grant
  always_comb begin
    chOpen = {1'b1, ~in_c1TxAlmFull, ~in_c0TxAlmFull};
    req0   = {in_s0_c2_notEmpty, in_s0_c1_notEmpty, in_s0_c0_notEmpty} & chOpen & {3{~reset}};
    req1   = {in_s1_c2_notEmpty, in_s1_c1_notEmpty, in_s1_c0_notEmpty} & chOpen & {3{~reset}};
    gnt0   = req0 & (~req1 | lastGnt);
    gnt1   = req1 & (~req0 | ~lastGnt);
  end

  assign out_s0_c0_deq_en = gnt0[0];
  assign out_s0_c1_deq_en = gnt0[1];
  assign out_s0_c2_deq_en = gnt0[2];
  assign out_s1_c0_deq_en = gnt1[0];
  assign out_s1_c1_deq_en = gnt1[1];
  assign out_s1_c2_deq_en = gnt1[2];

  always_ff @(posedge clk) begin
    if (reset) lastGnt <= {3{~PRIO}};
    else       lastGnt <= gnt1 | (lastGnt & ~(gnt0 | gnt1));
  end

  // Idle channels load zero so no stale payload lingers on the port
  always_comb begin
    nxtTx = '0;
    if (gnt0[0] | gnt1[0]) begin
      nxtTx.c0       = gnt1[0] ? in_s1_c0_first : in_s0_c0_first;
      nxtTx.c0.valid = 1'b1;
    end
    if (gnt0[1] | gnt1[1]) begin
      nxtTx.c1       = gnt1[1] ? in_s1_c1_first : in_s0_c1_first;
      nxtTx.c1.valid = 1'b1;
    end
    if (gnt0[2] | gnt1[2]) begin
      nxtTx.c2             = gnt1[2] ? in_s1_c2_first : in_s0_c2_first;
      nxtTx.c2.mmioRdValid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) out_TxPort <= '0;
    else       out_TxPort <= nxtTx;
  end

`ifdef TX_ARB_STATS_EN
  logic [2:0][1:0][STAT_WIDTH-1:0] statCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      statCnt <= '0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (gnt0[n]) statCnt[n][0] <= statCnt[n][0] + STAT_WIDTH'(1);
        if (gnt1[n]) statCnt[n][1] <= statCnt[n][1] + STAT_WIDTH'(1);
      end
    end
  end

  assign out_stat_c0_cnt = {statCnt[0][1], statCnt[0][0]};
  assign out_stat_c1_cnt = {statCnt[1][1], statCnt[1][0]};
  assign out_stat_c2_cnt = {statCnt[2][1], statCnt[2][0]};
`else
  assign out_stat_c0_cnt = '0;
  assign out_stat_c1_cnt = '0;
  assign out_stat_c2_cnt = '0;
`endif

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// Bench for tx_fifo_arbiter: queue-based source FIFOs and a rule-level arbitration model.
// Stats expectations follow TX_ARB_STATS_EN as compiled.

module tb_tx_fifo_arbiter;
  import tx_fifo_arbiter_pkg::*;

  localparam int unsigned PRIO = 0;
  localparam int unsigned SW   = 4;
  localparam int unsigned W0   = $bits(t_if_ccip_c0_Tx);
  localparam int unsigned W1   = $bits(t_if_ccip_c1_Tx);
  localparam int unsigned W2   = $bits(t_if_ccip_c2_Tx);

  logic clk = 1'b0;
  logic reset;
  logic in_s0_c0_notEmpty, in_s1_c0_notEmpty, in_s0_c1_notEmpty;
  logic in_s1_c1_notEmpty, in_s0_c2_notEmpty, in_s1_c2_notEmpty;
  t_if_ccip_c0_Tx in_s0_c0_first, in_s1_c0_first;
  t_if_ccip_c1_Tx in_s0_c1_first, in_s1_c1_first;
  t_if_ccip_c2_Tx in_s0_c2_first, in_s1_c2_first;
  logic out_s0_c0_deq_en, out_s1_c0_deq_en, out_s0_c1_deq_en;
  logic out_s1_c1_deq_en, out_s0_c2_deq_en, out_s1_c2_deq_en;
  logic in_c0TxAlmFull, in_c1TxAlmFull;
  t_if_ccip_Tx out_TxPort;
  logic [2*SW-1:0] out_stat_c0_cnt, out_stat_c1_cnt, out_stat_c2_cnt;

  tx_fifo_arbiter #(.PRIORITY_SRC(PRIO), .STAT_WIDTH(SW)) dut (
    .clk(clk), .reset(reset),
    .in_s0_c0_notEmpty(in_s0_c0_notEmpty), .in_s0_c0_first(in_s0_c0_first), .out_s0_c0_deq_en(out_s0_c0_deq_en),
    .in_s1_c0_notEmpty(in_s1_c0_notEmpty), .in_s1_c0_first(in_s1_c0_first), .out_s1_c0_deq_en(out_s1_c0_deq_en),
    .in_s0_c1_notEmpty(in_s0_c1_notEmpty), .in_s0_c1_first(in_s0_c1_first), .out_s0_c1_deq_en(out_s0_c1_deq_en),
    .in_s1_c1_notEmpty(in_s1_c1_notEmpty), .in_s1_c1_first(in_s1_c1_first), .out_s1_c1_deq_en(out_s1_c1_deq_en),
    .in_s0_c2_notEmpty(in_s0_c2_notEmpty), .in_s0_c2_first(in_s0_c2_first), .out_s0_c2_deq_en(out_s0_c2_deq_en),
    .in_s1_c2_notEmpty(in_s1_c2_notEmpty), .in_s1_c2_first(in_s1_c2_first), .out_s1_c2_deq_en(out_s1_c2_deq_en),
    .in_c0TxAlmFull(in_c0TxAlmFull), .in_c1TxAlmFull(in_c1TxAlmFull),
    .out_TxPort(out_TxPort),
    .out_stat_c0_cnt(out_stat_c0_cnt), .out_stat_c1_cnt(out_stat_c1_cnt), .out_stat_c2_cnt(out_stat_c2_cnt)
  );

  always #5 clk = ~clk;

  // Source FIFO contents (front = show-ahead head)
  t_if_ccip_c0_Tx s0c0Q[$], s1c0Q[$];
  t_if_ccip_c1_Tx s0c1Q[$], s1c1Q[$];
  t_if_ccip_c2_Tx s0c2Q[$], s1c2Q[$];

  int unsigned checks   = 0;
  int unsigned failures = 0;
  bit [2:0]    prefer;          // source that wins the next tie, per channel
  int unsigned statM [3][2];
  logic [5:0]  lastDeq;         // {s1c2,s1c1,s1c0,s0c2,s0c1,s0c0}

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic t_if_ccip_c0_Tx rndC0();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W0-1:0];
  endfunction

  function automatic t_if_ccip_c1_Tx rndC1();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W1-1:0];
  endfunction

  function automatic t_if_ccip_c2_Tx rndC2();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W2-1:0];
  endfunction

  task automatic push(input int src, input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      case ({src[0], 2'(ch)})
        3'b000: s0c0Q.push_back(rndC0());
        3'b100: s1c0Q.push_back(rndC0());
        3'b001: s0c1Q.push_back(rndC1());
        3'b101: s1c1Q.push_back(rndC1());
        3'b010: s0c2Q.push_back(rndC2());
        default: s1c2Q.push_back(rndC2());
      endcase
    end
  endtask

  // Heads come from the queues; an empty FIFO shows garbage that must never leak.
  task automatic driveInputs();
    in_s0_c0_notEmpty = (s0c0Q.size() != 0);
    in_s1_c0_notEmpty = (s1c0Q.size() != 0);
    in_s0_c1_notEmpty = (s0c1Q.size() != 0);
    in_s1_c1_notEmpty = (s1c1Q.size() != 0);
    in_s0_c2_notEmpty = (s0c2Q.size() != 0);
    in_s1_c2_notEmpty = (s1c2Q.size() != 0);
    in_s0_c0_first = rndC0(); if (s0c0Q.size() != 0) in_s0_c0_first = s0c0Q[0];
    in_s1_c0_first = rndC0(); if (s1c0Q.size() != 0) in_s1_c0_first = s1c0Q[0];
    in_s0_c1_first = rndC1(); if (s0c1Q.size() != 0) in_s0_c1_first = s0c1Q[0];
    in_s1_c1_first = rndC1(); if (s1c1Q.size() != 0) in_s1_c1_first = s1c1Q[0];
    in_s0_c2_first = rndC2(); if (s0c2Q.size() != 0) in_s0_c2_first = s0c2Q[0];
    in_s1_c2_first = rndC2(); if (s1c2Q.size() != 0) in_s1_c2_first = s1c2Q[0];
  endtask

  // One clock of stimulus + checking; entered and left at posedge+1.
  task automatic step(input bit rst);
    bit [1:0][2:0] ne;
    bit [2:0] open, gr, win;
    bit e0, e1;
    t_if_ccip_Tx expTx;
    logic [2*SW-1:0] expStat [3];
    logic [2*SW-1:0] obsStat [3];
    reset = rst;
    driveInputs();
    ne[0] = {s0c2Q.size() != 0, s0c1Q.size() != 0, s0c0Q.size() != 0};
    ne[1] = {s1c2Q.size() != 0, s1c1Q.size() != 0, s1c0Q.size() != 0};
    open  = {1'b1, !in_c1TxAlmFull, !in_c0TxAlmFull};
    for (int ch = 0; ch < 3; ch++) begin
      e0 = ne[0][ch] && open[ch] && !rst;
      e1 = ne[1][ch] && open[ch] && !rst;
      gr[ch]  = e0 || e1;
      win[ch] = (e0 && e1) ? prefer[ch] : e1;
    end
    expTx = '0;
    if (gr[0]) begin expTx.c0 = win[0] ? s1c0Q[0] : s0c0Q[0]; expTx.c0.valid = 1'b1; end
    if (gr[1]) begin expTx.c1 = win[1] ? s1c1Q[0] : s0c1Q[0]; expTx.c1.valid = 1'b1; end
    if (gr[2]) begin expTx.c2 = win[2] ? s1c2Q[0] : s0c2Q[0]; expTx.c2.mmioRdValid = 1'b1; end
    #2;
    lastDeq = {out_s1_c2_deq_en, out_s1_c1_deq_en, out_s1_c0_deq_en,
               out_s0_c2_deq_en, out_s0_c1_deq_en, out_s0_c0_deq_en};
    check("deq_en", 128'(lastDeq), 128'({gr & win, gr & ~win}));
    @(posedge clk);
    #1;
    check("tx_port", 128'(out_TxPort), 128'(expTx));
    for (int ch = 0; ch < 3; ch++) begin
      if (rst) begin
        prefer[ch] = 1'(PRIO);
        statM[ch][0] = 0;
        statM[ch][1] = 0;
      end else if (gr[ch]) begin
        prefer[ch] = !win[ch];
        statM[ch][win[ch]] = (statM[ch][win[ch]] + 1) % (1 << SW);
      end
    end
    if (gr[0]) begin if (win[0]) void'(s1c0Q.pop_front()); else void'(s0c0Q.pop_front()); end
    if (gr[1]) begin if (win[1]) void'(s1c1Q.pop_front()); else void'(s0c1Q.pop_front()); end
    if (gr[2]) begin if (win[2]) void'(s1c2Q.pop_front()); else void'(s0c2Q.pop_front()); end
    obsStat[0] = out_stat_c0_cnt;
    obsStat[1] = out_stat_c1_cnt;
    obsStat[2] = out_stat_c2_cnt;
    for (int ch = 0; ch < 3; ch++) begin
`ifdef TX_ARB_STATS_EN
      expStat[ch] = {SW'(statM[ch][1]), SW'(statM[ch][0])};
`else
      expStat[ch] = '0;
`endif
      check($sformatf("stat_c%0d", ch), 128'(obsStat[ch]), 128'(expStat[ch]));
    end
  endtask

  initial begin
    int cnt;
    int cntB;
    reset = 1'b1;
    in_c0TxAlmFull = 1'b0;
    in_c1TxAlmFull = 1'b0;
    prefer = {3{1'(PRIO)}};
    for (int ch = 0; ch < 3; ch++) begin statM[ch][0] = 0; statM[ch][1] = 0; end

    // Reset state
    step(1'b1);
    step(1'b1);
    check("reset_tx_zero", 128'(out_TxPort), 128'(0));

    // Single source: three s0 c0 entries issue back-to-back
    push(0, 0, 3);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin step(1'b0); cnt += int'(lastDeq[0]); end
    check("single_src_issues", 128'(cnt), 128'(3));

    // Contention on c1: 8 issues in 8 cycles, alternating
    push(0, 1, 4);
    push(1, 1, 4);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      cnt += int'(lastDeq[1]) + int'(lastDeq[4]);
      check("c1_alternate", 128'({lastDeq[4], lastDeq[1]}), 128'((i % 2 == 0) ? 2'b01 : 2'b10));
    end
    check("c1_contention_issues", 128'(cnt), 128'(8));

    // c0 almost full: no c0 issue, c1/c2 keep flowing
    push(0, 0, 6); push(1, 0, 6);
    push(0, 1, 3); push(1, 1, 3);
    push(0, 2, 3);
    in_c0TxAlmFull = 1'b1;
    cnt = 0;
    cntB = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      cnt  += int'(lastDeq[0]) + int'(lastDeq[3]);
      cntB += int'(lastDeq[1]) + int'(lastDeq[4]);
    end
    check("almfull_c0_blocked", 128'(cnt), 128'(0));
    check("almfull_c1_flows", 128'(cntB), 128'(5));
    in_c0TxAlmFull = 1'b0;
    step(1'b0);
    check("almfull_c0_resumes", 128'(lastDeq[0] | lastDeq[3]), 128'(1));
    for (int i = 0; i < 14; i++) step(1'b0);

    // Concurrency across channels
    push(0, 0, 1); push(1, 1, 1); push(0, 2, 1);
    step(1'b0);
    check("concurrent_deq", 128'(lastDeq), 128'(6'b010101));
    check("concurrent_valid", 128'({out_TxPort.c0.valid, out_TxPort.c1.valid, out_TxPort.c2.mmioRdValid}), 128'(3'b111));

    // Reset during a contention burst
    push(0, 1, 4); push(1, 1, 4);
    for (int i = 0; i < 3; i++) step(1'b0);
    step(1'b1);
    check("reset_mid_deq", 128'(lastDeq), 128'(0));
    check("reset_mid_tx", 128'(out_TxPort), 128'(0));
    step(1'b0);
    check("tie_after_reset", 128'({lastDeq[4], lastDeq[1]}), 128'(PRIO == 0 ? 2'b01 : 2'b10));
    for (int i = 0; i < 6; i++) step(1'b0);

    // Stats wrap: 17 s0 c2 grants from a fresh reset
    step(1'b1);
    push(0, 2, 17);
    for (int i = 0; i < 17; i++) step(1'b0);
`ifdef TX_ARB_STATS_EN
    check("stat_c2_wrap", 128'(out_stat_c2_cnt), 128'(8'h01));
`else
    check("stat_c2_tied_zero", 128'(out_stat_c2_cnt), 128'(8'h00));
`endif

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      for (int s = 0; s < 2; s++)
        for (int ch = 0; ch < 3; ch++)
          if ($urandom_range(0, 2) == 0) push(s, ch, 1);
      in_c0TxAlmFull = ($urandom_range(0, 3) == 0);
      in_c1TxAlmFull = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 63) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
